// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared types and constants for the fetch/PC unit.
// Holds the fetch FSM state enum, the default reset PC, MIPS opcodes and a word-align helper.
package fetch_pc_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_ERR
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory request/response bus.
// master (fetch unit): drives imem_req, imem_addr; slave (memory): drives imem_valid, imem_rdata.
interface fetch_pc_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// fetch_pc_unit_next_pc_calc: combinational next-PC select (jump > taken branch > pc+4).
// In: pc_plus4, instr[26:0], branch, jump, zero. Out: next_pc (+ taken with FETCH_PERF_CNT_EN).
module fetch_pc_unit_next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [26:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
`ifdef FETCH_PERF_CNT_EN
    output logic        taken,
`endif
    output logic [31:0] next_pc
);

    logic        br_taken;
    logic [31:0] jump_tgt;
    logic [31:0] br_tgt;

    // Control drives the same Branch for beq and bne; opcode bit 26 tells them apart.
    assign br_taken = branch & (instr[26] ? ~zero : zero);
    assign jump_tgt = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign br_tgt   = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            jump:     next_pc = jump_tgt;
            br_taken: next_pc = br_tgt;
            default:  next_pc = pc_plus4;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    assign taken = jump | br_taken;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register + imem fetch FSM (IDLE/REQ/WAIT/EXEC/ERR) for a single-cycle MIPS32.
// Ports: clk, rst (async high), imem bus (master), instr/instr_valid/pc/pc_plus4 out,
// branch/jump/zero/stall in, sticky fetch_err. FETCH_PERF_CNT_EN adds instr_count/taken_count.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int          IMEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_pc_unit_if.master        imem,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    input  logic                   branch,
    input  logic                   jump,
    input  logic                   zero,
    input  logic                   stall,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]            instr_count,
    output logic [31:0]            taken_count,
`endif
    output logic                   fetch_err
);

    localparam int CW = $clog2(IMEM_TIMEOUT + 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;
    logic [CW-1:0] cnt_inc;
    logic         timeout_hit;
    logic [31:0]  next_pc;
    logic         exec_fire;

    assign pc_plus4    = pc_q + 32'd4;
    assign cnt_inc     = cnt_q + CW'(1);
    assign timeout_hit = (cnt_inc == CW'(IMEM_TIMEOUT));

    fetch_pc_unit_next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q[26:0]),
        .branch   (branch),
        .jump     (jump),
        .zero     (zero),
`ifdef FETCH_PERF_CNT_EN
        .taken    (taken),
`endif
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        exec_fire = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A valid arriving on the timeout cycle still wins.
                if (imem.imem_valid) begin
                    instr_d = imem.imem_rdata;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d      = align_word(next_pc);
                    exec_fire = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= align_word(RESET_PC);
            instr_q <= 32'h0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_WAIT);
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == S_EXEC);
    assign pc             = pc_q;
    assign fetch_err      = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic        taken;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (exec_fire) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
            if (taken) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q <= 32'h0;
            taken_cnt_q <= 32'h0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign instr_count = instr_cnt_q;
    assign taken_count = taken_cnt_q;
`else
    logic unused_exec_fire;
    assign unused_exec_fire = exec_fire;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed self-checking bench for fetch_pc_unit.
// Main DUT uses RESET_PC=0x100; a second DUT at 0x3000_0000 covers jump priority.
module tb_fetch_pc_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic branch = 0, jump = 0, zero = 0, stall = 0;
    logic branch2 = 0, jump2 = 0, zero2 = 0;
    logic [31:0] instr, pc, pc_plus4, instr2, pc2, pc_plus4_2;
    logic instr_valid, fetch_err, instr_valid2, fetch_err2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ic1, tc1, ic2, tc2;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit_if imem_if ();
    fetch_pc_unit_if imem_if2 ();

    fetch_pc_unit #(.RESET_PC(32'h0000_0100), .IMEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .imem(imem_if),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .branch(branch), .jump(jump), .zero(zero), .stall(stall),
`ifdef FETCH_PERF_CNT_EN
        .instr_count(ic1), .taken_count(tc1),
`endif
        .fetch_err(fetch_err)
    );

    fetch_pc_unit #(.RESET_PC(32'h3000_0000), .IMEM_TIMEOUT(15)) dut2 (
        .clk(clk), .rst(rst2), .imem(imem_if2),
        .instr(instr2), .instr_valid(instr_valid2),
        .pc(pc2), .pc_plus4(pc_plus4_2),
        .branch(branch2), .jump(jump2), .zero(zero2), .stall(1'b0),
`ifdef FETCH_PERF_CNT_EN
        .instr_count(ic2), .taken_count(tc2),
`endif
        .fetch_err(fetch_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in REQ; leaves at the negedge of the next REQ.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic b, input logic j, input logic z,
                            input int nstall, input logic [31:0] exp_next);
        chk({tag, " req"}, {31'b0, imem_if.imem_req}, 32'd1);
        chk({tag, " addr"}, imem_if.imem_addr, addr);
        @(negedge clk);
        chk({tag, " wait_req"}, {31'b0, imem_if.imem_req}, 32'd1);
        imem_if.imem_valid = 1'b1;
        imem_if.imem_rdata = data;
        @(negedge clk);
        imem_if.imem_valid = 1'b0;
        chk({tag, " ivalid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, " instr"}, instr, data);
        chk({tag, " exec_req"}, {31'b0, imem_if.imem_req}, 32'd0);
        chk({tag, " pc"}, pc, addr);
        chk({tag, " pc4"}, pc_plus4, addr + 32'd4);
        branch = b;
        jump = j;
        zero = z;
        stall = (nstall > 0);
        for (int i = 0; i < nstall; i++) begin
            imem_if.imem_valid = 1'b1;
            imem_if.imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk({tag, " stall_ivalid"}, {31'b0, instr_valid}, 32'd1);
            chk({tag, " stall_instr"}, instr, data);
            chk({tag, " stall_pc"}, pc, addr);
            chk({tag, " stall_req"}, {31'b0, imem_if.imem_req}, 32'd0);
        end
        stall = 1'b0;
        imem_if.imem_valid = 1'b0;
        @(negedge clk);
        chk({tag, " next_pc"}, pc, exp_next);
        chk({tag, " next_ivalid"}, {31'b0, instr_valid}, 32'd0);
        branch = 0;
        jump = 0;
        zero = 0;
    endtask

    initial begin
        imem_if.imem_valid = 1'b0;
        imem_if.imem_rdata = 32'h0;
        imem_if2.imem_valid = 1'b0;
        imem_if2.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst pc", pc, 32'h100);
        chk("rst instr", instr, 32'h0);
        chk("rst ivalid", {31'b0, instr_valid}, 32'd0);
        chk("rst req", {31'b0, imem_if.imem_req}, 32'd0);
        chk("rst err", {31'b0, fetch_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_fetch("nop", 32'h100, 32'h0000_0020, 0, 0, 0, 0, 32'h104);
        do_fetch("beq_t", 32'h104, 32'h1000_0003, 1, 0, 1, 0, 32'h114);
        do_fetch("beq_nt", 32'h114, 32'h1000_0003, 1, 0, 0, 0, 32'h118);
        do_fetch("j_200", 32'h118, 32'h0800_0080, 0, 1, 0, 0, 32'h200);
        do_fetch("bne_t", 32'h200, 32'h1400_FFFF, 1, 0, 0, 0, 32'h200);
        do_fetch("bne_nt", 32'h200, 32'h1400_FFFF, 1, 0, 1, 4, 32'h204);
        do_fetch("beq_nobr", 32'h204, 32'h1000_0003, 0, 0, 1, 0, 32'h208);

        // Timeout: 15 WAIT cycles then ERR.
        chk("to addr", imem_if.imem_addr, 32'h208);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("to wait_req", {31'b0, imem_if.imem_req}, 32'd1);
            chk("to wait_err", {31'b0, fetch_err}, 32'd0);
        end
        @(negedge clk);
        chk("to err", {31'b0, fetch_err}, 32'd1);
        chk("to req", {31'b0, imem_if.imem_req}, 32'd0);
        imem_if.imem_valid = 1'b1;
        imem_if.imem_rdata = 32'hCAFE_0000;
        repeat (5) @(negedge clk);
        chk("err sticky", {31'b0, fetch_err}, 32'd1);
        chk("err req", {31'b0, imem_if.imem_req}, 32'd0);
        chk("err instr", instr, 32'h1000_0003);
        chk("err ivalid", {31'b0, instr_valid}, 32'd0);
        chk("err pc", pc, 32'h208);
        imem_if.imem_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("err_rst pc", pc, 32'h100);
        chk("err_rst err", {31'b0, fetch_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Valid arriving in the 15th WAIT cycle is a success.
        chk("edge addr", imem_if.imem_addr, 32'h100);
        for (int i = 0; i < 14; i++) @(negedge clk);
        @(negedge clk);
        chk("edge req", {31'b0, imem_if.imem_req}, 32'd1);
        imem_if.imem_valid = 1'b1;
        imem_if.imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_if.imem_valid = 1'b0;
        chk("edge ivalid", {31'b0, instr_valid}, 32'd1);
        chk("edge err", {31'b0, fetch_err}, 32'd0);
        chk("edge instr", instr, 32'h20);
        @(negedge clk);
        chk("edge next_pc", pc, 32'h104);

        // Reset mid-WAIT with a response in flight.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        imem_if.imem_valid = 1'b1;
        imem_if.imem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("mid_rst pc", pc, 32'h100);
        chk("mid_rst req", {31'b0, imem_if.imem_req}, 32'd0);
        chk("mid_rst instr", instr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst req", {31'b0, imem_if.imem_req}, 32'd1);
        chk("post_rst addr", imem_if.imem_addr, 32'h100);
        chk("post_rst instr", instr, 32'h0);
        imem_if.imem_valid = 1'b0;
        @(negedge clk);
        chk("post_rst wait_instr", instr, 32'h0);
        chk("post_rst ivalid", {31'b0, instr_valid}, 32'd0);

        // Jump beats a simultaneously taken branch.
        rst2 = 1'b0;
        @(negedge clk);
        chk("j2 addr", imem_if2.imem_addr, 32'h3000_0000);
        @(negedge clk);
        imem_if2.imem_valid = 1'b1;
        imem_if2.imem_rdata = 32'h0800_0040;
        @(negedge clk);
        imem_if2.imem_valid = 1'b0;
        chk("j2 ivalid", {31'b0, instr_valid2}, 32'd1);
        chk("j2 instr", instr2, 32'h0800_0040);
        jump2 = 1'b1;
        branch2 = 1'b1;
        zero2 = 1'b1;
        @(negedge clk);
        chk("j2 next_pc", pc2, 32'h3000_0100);
        chk("j2 err", {31'b0, fetch_err2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
